// File: rtl/read_iq_packer.sv
// -----------------------------------------------------------------------------
// read_iq_packer
//
// Byte-to-sample front end for the complex FIR channel filter. Pops interleaved
// I/Q bytes (I lo, I hi, Q lo, Q hi) from a first-word-fall-through byte FIFO,
// assembles 16-bit little-endian words, sign-extends them to 32 bits and
// shifts them left by QUANT_BITS, then writes the I/Q pair into the FIR input
// FIFO through a write-enable / full handshake.
//
// Ports:
//   clock        - sole clock, rising edge
//   reset        - asynchronous, active-low reset
//   in_dout      - head byte of the upstream byte FIFO
//   in_empty     - upstream FIFO empty
//   in_rd_en     - pops the head byte (combinational)
//   i_out        - quantized I sample (registered)
//   q_out        - quantized Q sample (registered)
//   out_wr_en    - writes {i_out, q_out} into the FIR input FIFO
//   out_full     - FIR input FIFO full
//   sample_count - samples written since reset (only with READ_IQ_COUNT_EN)
//
// Optional feature macro: READ_IQ_COUNT_EN adds the sample_count output.
// -----------------------------------------------------------------------------
module read_iq_packer #(
    parameter int QUANT_BITS = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_dout,
    input  logic        in_empty,
    output logic        in_rd_en,
    output logic [31:0] i_out,
    output logic [31:0] q_out,
    output logic        out_wr_en,
    input  logic        out_full
`ifdef READ_IQ_COUNT_EN
    ,
    output logic [31:0] sample_count
`endif
);

    typedef enum logic [2:0] {
        S_I_LO  = 3'd0,
        S_I_HI  = 3'd1,
        S_Q_LO  = 3'd2,
        S_Q_HI  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t      state_r;
    logic [7:0]  i_lo_r;
    logic [7:0]  q_lo_r;
    logic        gather_s;
    logic        pop_s;
    logic        write_s;

    // Sign-extend a 16-bit word and scale it; bits shifted past bit 31 are lost.
    function automatic logic [31:0] quantize(input logic [15:0] word);
        logic [31:0] ext;
        ext = {{16{word[15]}}, word};
        return ext << QUANT_BITS;
    endfunction

    // Handshake decode: pop in any gather state with data, write when not full.
    always_comb begin
        gather_s = 1'b0;
        write_s  = 1'b0;
        case (state_r)
            S_I_LO, S_I_HI, S_Q_LO, S_Q_HI: gather_s = 1'b1;
            S_WRITE:                        write_s  = !out_full;
            default: begin
                gather_s = 1'b0;
                write_s  = 1'b0;
            end
        endcase
        // Reset level gates the pop so no byte is lost while held in reset.
        if (reset && gather_s && !in_empty) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    assign in_rd_en  = pop_s;
    assign out_wr_en = write_s;

    // Byte-gathering FSM and sample output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_I_LO;
            i_lo_r  <= 8'd0;
            q_lo_r  <= 8'd0;
            i_out   <= 32'd0;
            q_out   <= 32'd0;
        end else begin
            case (state_r)
                S_I_LO: begin
                    if (pop_s) begin
                        i_lo_r  <= in_dout;
                        state_r <= S_I_HI;
                    end
                end
                S_I_HI: begin
                    if (pop_s) begin
                        i_out   <= quantize({in_dout, i_lo_r});
                        state_r <= S_Q_LO;
                    end
                end
                S_Q_LO: begin
                    if (pop_s) begin
                        q_lo_r  <= in_dout;
                        state_r <= S_Q_HI;
                    end
                end
                S_Q_HI: begin
                    if (pop_s) begin
                        q_out   <= quantize({in_dout, q_lo_r});
                        state_r <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Outputs stay put while the FIR FIFO is full.
                    if (write_s) begin
                        state_r <= S_I_LO;
                    end
                end
                default: begin
                    state_r <= S_I_LO;
                end
            endcase
        end
    end

`ifdef READ_IQ_COUNT_EN
    // Count written samples; wraps naturally at 32 bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sample_count <= 32'd0;
        end else if (write_s) begin
            sample_count <= sample_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_read_iq_packer.sv
// -----------------------------------------------------------------------------
// tb_read_iq_packer
//
// Directed and randomized bench for read_iq_packer. A queue models the
// upstream byte FIFO; a second queue holds the expected {i,q} words computed
// arithmetically from each sample pushed.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_read_iq_packer;

    localparam int QB = 10;

    logic        clock;
    logic        reset;
    logic [7:0]  in_dout;
    logic        in_empty;
    logic        in_rd_en;
    logic [31:0] i_out;
    logic [31:0] q_out;
    logic        out_wr_en;
    logic        out_full;
`ifdef READ_IQ_COUNT_EN
    logic [31:0] sample_count;
`endif

    read_iq_packer #(.QUANT_BITS(QB)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_dout   (in_dout),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .i_out     (i_out),
        .q_out     (q_out),
        .out_wr_en (out_wr_en),
        .out_full  (out_full)
`ifdef READ_IQ_COUNT_EN
        ,
        .sample_count (sample_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [7:0]  src_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] last_wr = 64'd0;
    int          pops = 0;
    int          writes = 0;
    int          writes_since_rst = 0;
    int          gap_cnt = 0;
    bit          gap_mode = 1'b0;
    bit          rand_empty = 1'b0;
    bit          rand_full = 1'b0;
    logic        s_rd, s_wr;
    logic [31:0] s_i, s_q;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference quantizer: signed value times 2^QB, kept modulo 2^32.
    function automatic logic [31:0] ref_quant(input logic [15:0] w);
        int     s;
        longint v;
        s = $signed(w);
        v = longint'(s) * (longint'(1) << QB);
        return v[31:0];
    endfunction

    task automatic drive_src();
        if (src_q.size() == 0 || gap_cnt > 0 ||
            (rand_empty && $urandom_range(0, 3) == 0)) begin
            in_empty = 1'b1;
            in_dout  = 8'($urandom);
        end else begin
            in_empty = 1'b0;
            in_dout  = src_q[0];
        end
    endtask

    task automatic push_raw(input logic [7:0] b);
        src_q.push_back(b);
        drive_src();
    endtask

    task automatic push_sample(input logic [15:0] iw, input logic [15:0] qw);
        src_q.push_back(iw[7:0]);
        src_q.push_back(iw[15:8]);
        src_q.push_back(qw[7:0]);
        src_q.push_back(qw[15:8]);
        exp_q.push_back({ref_quant(iw), ref_quant(qw)});
        drive_src();
    endtask

    // One clock: sample at negedge, score pops/writes, update inputs after edge.
    task automatic cycle();
        bit popped;
        popped = 1'b0;
        @(negedge clock);
        s_rd = in_rd_en;
        s_wr = out_wr_en;
        s_i  = i_out;
        s_q  = q_out;
        if (s_rd === 1'b1) begin
            chk("pop_while_empty", 64'(in_empty), 64'd0);
            if (src_q.size() > 0) void'(src_q.pop_front());
            pops++;
            popped = 1'b1;
        end
        if (s_wr === 1'b1) begin
            chk("write_while_full", 64'(out_full), 64'd0);
            chk("write_has_expect", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                chk("sample_value", {s_i, s_q}, exp_q[0]);
                void'(exp_q.pop_front());
            end
            writes++;
            writes_since_rst++;
            last_wr = {s_i, s_q};
        end
        @(posedge clock);
        #1;
        if (rand_full) out_full = ($urandom_range(0, 2) == 0);
        if (popped && gap_mode) gap_cnt = 3;
        else if (gap_cnt > 0) gap_cnt--;
        drive_src();
    endtask

    task automatic run_until_pops(input int target, input int budget);
        int n;
        n = 0;
        while (pops < target && n < budget) begin
            cycle();
            n++;
        end
        chk("pop_timeout", 64'(pops >= target), 64'd1);
    endtask

    task automatic run_until_writes(input int target, input int budget);
        int n;
        n = 0;
        while (writes < target && n < budget) begin
            cycle();
            n++;
        end
        chk("write_timeout", 64'(writes >= target), 64'd1);
    endtask

    // Reset pulse with a non-empty source to prove pops are suppressed.
    task automatic reset_pulse();
        reset = 1'b0;
        writes_since_rst = 0;
        @(negedge clock);
        chk("rst_rd_en", 64'(in_rd_en), 64'd0);
        chk("rst_wr_en", 64'(out_wr_en), 64'd0);
        chk("rst_i_out", 64'(i_out), 64'd0);
        chk("rst_q_out", 64'(q_out), 64'd0);
`ifdef READ_IQ_COUNT_EN
        chk("rst_count", 64'(sample_count), 64'd0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b1;
        drive_src();
    endtask

    initial begin
        int p0;
        reset    = 1'b0;
        out_full = 1'b0;
        in_empty = 1'b1;
        in_dout  = 8'd0;
        @(posedge clock);
        #1;
        src_q.push_back(8'h5A);          // present a byte during reset
        drive_src();
        reset_pulse();
        src_q.delete();
        drive_src();

        // Basic sample with exact latency: four pops then one write.
        push_sample(16'h0001, 16'hFFFF);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("basic_pop", 64'(s_rd), 64'd1);
            chk("basic_no_wr", 64'(s_wr), 64'd0);
        end
        cycle();
        chk("basic_wr", 64'(s_wr), 64'd1);
        chk("basic_rd_in_write", 64'(s_rd), 64'd0);
        chk("basic_value", last_wr, 64'h00000400_FFFFFC00);

        // Extreme values: most negative I, most positive Q.
        push_sample(16'h8000, 16'h7FFF);
        run_until_writes(writes + 1, 50);
        chk("extreme_value", last_wr, 64'hFE000000_01FFFC00);

        // Three empty cycles after every byte: same result, exactly four pops.
        gap_mode = 1'b1;
        p0 = pops;
        push_sample(16'h1234, 16'hABCD);
        run_until_writes(writes + 1, 100);
        chk("gap_pop_count", 64'(pops - p0), 64'd4);
        chk("gap_value", last_wr, {ref_quant(16'h1234), ref_quant(16'hABCD)});
        gap_mode = 1'b0;
        gap_cnt  = 0;

        // Backpressure: hold ten cycles in the write state with data waiting.
        out_full = 1'b1;
        push_sample(16'h00F0, 16'hFF0F);
        run_until_pops(pops + 4, 50);
        push_sample(16'h7777, 16'h8888);
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("bp_no_wr", 64'(s_wr), 64'd0);
            chk("bp_no_rd", 64'(s_rd), 64'd0);
            chk("bp_stable", {s_i, s_q}, {ref_quant(16'h00F0), ref_quant(16'hFF0F)});
        end
        out_full = 1'b0;
        cycle();
        chk("bp_release_wr", 64'(s_wr), 64'd1);
        run_until_writes(writes + 1, 50);
        chk("bp_next_value", last_wr, {ref_quant(16'h7777), ref_quant(16'h8888)});

        // Reset after two bytes: partial sample discarded.
        push_raw(8'h01);
        push_raw(8'h02);
        run_until_pops(pops + 2, 50);
        push_sample(16'h0010, 16'h0020);
        reset_pulse();
        run_until_writes(writes + 1, 50);
        chk("rst_mid_value", last_wr, 64'h00004000_00008000);

        // 100 random samples with random empties and backpressure.
        reset_pulse();
        rand_empty = 1'b1;
        rand_full  = 1'b1;
        p0 = writes;
        for (int k = 0; k < 100; k++) begin
            push_sample(16'($urandom), 16'($urandom));
        end
        run_until_writes(p0 + 100, 5000);
        rand_empty = 1'b0;
        rand_full  = 1'b0;
        out_full   = 1'b0;
        cycle();
        cycle();
        chk("stream_exp_left", 64'(exp_q.size()), 64'd0);
        chk("stream_src_left", 64'(src_q.size()), 64'd0);
        chk("stream_writes", 64'(writes_since_rst), 64'd100);
`ifdef READ_IQ_COUNT_EN
        chk("stream_count", 64'(sample_count), 64'd100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
